uart_int_ctrl: RTL and testbench

- Interrupt controller that sits directly downstream of the per-source interrupt latches.
- Collects their latched pending bits and applies per-source mask and global enable.
- Selects one source by fixed or round-robin priority and presents a single IRQ plus source ID to the CPU.
- On CPU acknowledge, issues a one-cycle CLEAR pulse back to the winning latch.

---
 rtl/uart_int_ctrl_pkg.sv | 15 +
 rtl/uart_int_prio.sv | 32 +++
 rtl/uart_int_ctrl.sv | 101 ++++++++++
 tb/tb_uart_int_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_int_ctrl_pkg.sv
// Shared types and default sizing for the UART interrupt controller.
// State encodings are fixed so status/debug readers can decode them.
package uart_int_ctrl_pkg;

    localparam int DEF_NUM_SRC = 8;
    localparam int DEF_ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        CLR    = 2'd2,
        GAP    = 2'd3
    } state_t;

endpackage

// File: rtl/uart_int_prio.sv
// Rotating priority encoder: first set bit of elig at or above ptr, wrapping.
// Fixed priority is the special case ptr = 0.
import uart_int_ctrl_pkg::*;

module uart_int_prio #(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_SRC-1:0] elig,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    id,
    output logic               hit
);

    int j;

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        id  = '0;
        hit = 1'b0;
        j   = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (elig[j[ID_W-1:0]]) begin
                id  = j[ID_W-1:0];
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_int_ctrl.sv
// Interrupt controller: masks/gates latched pending bits, presents one IRQ
// with source ID, and pulses CLEAR back to the winning latch on acknowledge.
import uart_int_ctrl_pkg::*;

module uart_int_ctrl #(
    parameter int NUM_SRC     = DEF_NUM_SRC,
    parameter int ID_W        = DEF_ID_W,
    parameter int ROUND_ROBIN = 0
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               GLOBAL_EN,
    input  logic [NUM_SRC-1:0] PEND,
    input  logic [NUM_SRC-1:0] MASK,
    input  logic               INT_ACK,
    output logic               IRQ,
    output logic [ID_W-1:0]    INT_ID,
    output logic [NUM_SRC-1:0] CLEAR,
    output logic [NUM_SRC-1:0] PEND_STATUS
);

    state_t             state, state_nxt;
    logic               irq_nxt;
    logic [ID_W-1:0]    id_nxt;
    logic [NUM_SRC-1:0] clear_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [ID_W-1:0]    ptr_sel;
    logic [NUM_SRC-1:0] elig;
    logic [ID_W-1:0]    win_id;
    logic               win_hit;

    assign elig    = GLOBAL_EN ? (PEND & ~MASK) : '0;
    assign ptr_sel = (ROUND_ROBIN != 0) ? ptr : '0;

    uart_int_prio #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .elig (elig),
        .ptr  (ptr_sel),
        .id   (win_id),
        .hit  (win_hit)
    );

    always_comb begin
        state_nxt = state;
        irq_nxt   = IRQ;
        id_nxt    = INT_ID;
        clear_nxt = '0;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (win_hit) begin
                    irq_nxt   = 1'b1;
                    id_nxt    = win_id;
                    state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                // Acknowledge takes precedence over a simultaneous withdraw.
                if (INT_ACK) begin
                    irq_nxt   = 1'b0;
                    clear_nxt = NUM_SRC'(1) << INT_ID;
                    state_nxt = CLR;
                end else if (!GLOBAL_EN || !PEND[INT_ID] || MASK[INT_ID]) begin
                    irq_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            CLR: begin
                if (ROUND_ROBIN != 0) begin
                    ptr_nxt = (int'(INT_ID) == NUM_SRC - 1) ? '0 : INT_ID + 1'b1;
                end
                state_nxt = GAP;
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state       <= IDLE;
            IRQ         <= 1'b0;
            INT_ID      <= '0;
            CLEAR       <= '0;
            PEND_STATUS <= '0;
            ptr         <= '0;
        end else begin
            state       <= state_nxt;
            IRQ         <= irq_nxt;
            INT_ID      <= id_nxt;
            CLEAR       <= clear_nxt;
            PEND_STATUS <= PEND & ~MASK;
            ptr         <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_uart_int_ctrl.sv
// Scoreboarded bench for uart_int_ctrl: fixed-priority and round-robin
// instances, expected source IDs queued at stimulus and popped on IRQ.
module tb_uart_int_ctrl;

    logic       CLK;
    logic       RESETn;
    logic       ge, ack, irq;
    logic [7:0] pend, mask, clear, pstat;
    logic [2:0] int_id;
    logic       ge_r, ack_r, irq_r;
    logic [7:0] pend_r, mask_r, clear_r, pstat_r;
    logic [2:0] int_id_r;

    int tests  = 0;
    int errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_id;

    uart_int_ctrl #(.NUM_SRC(8), .ID_W(3), .ROUND_ROBIN(0)) dut_fx (
        .CLK(CLK), .RESETn(RESETn), .GLOBAL_EN(ge), .PEND(pend),
        .MASK(mask), .INT_ACK(ack), .IRQ(irq), .INT_ID(int_id),
        .CLEAR(clear), .PEND_STATUS(pstat)
    );

    uart_int_ctrl #(.NUM_SRC(8), .ID_W(3), .ROUND_ROBIN(1)) dut_rr (
        .CLK(CLK), .RESETn(RESETn), .GLOBAL_EN(ge_r), .PEND(pend_r),
        .MASK(mask_r), .INT_ACK(ack_r), .IRQ(irq_r), .INT_ID(int_id_r),
        .CLEAR(clear_r), .PEND_STATUS(pstat_r)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESETn = 0; ge = 0; ack = 0; pend = 0; mask = 0;
        ge_r = 0; ack_r = 0; pend_r = 0; mask_r = 0;
        step(); step();
        tests++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
        tests++; if (int_id !== 3'd0) begin errors++; $display("FAIL rst_id got %0d exp 0", int_id); end
        tests++; if (clear !== 8'h00) begin errors++; $display("FAIL rst_clear got %h exp 00", clear); end
        tests++; if (pstat !== 8'h00) begin errors++; $display("FAIL rst_pstat got %h exp 00", pstat); end
        RESETn = 1;
        step();
    endtask

    task automatic test_fixed();
        ge = 1; mask = 0; pend = 8'h24;
        exp_q.push_back(3'd2);
        step();
        tests++; if (irq !== 1'b1) begin errors++; $display("FAIL fx_irq got %b exp 1", irq); end
        exp_id = exp_q.pop_front();
        tests++; if (int_id !== exp_id) begin errors++; $display("FAIL fx_id got %0d exp %0d", int_id, exp_id); end
        tests++; if (pstat !== 8'h24) begin errors++; $display("FAIL fx_pstat got %h exp 24", pstat); end
        step();
        tests++; if (irq !== 1'b1 || int_id !== 3'd2) begin errors++; $display("FAIL fx_hold got %b/%0d exp 1/2", irq, int_id); end
        ack = 1; step(); ack = 0;
        tests++; if (clear !== 8'h04) begin errors++; $display("FAIL fx_clear got %h exp 04", clear); end
        tests++; if (irq !== 1'b0) begin errors++; $display("FAIL fx_ackirq got %b exp 0", irq); end
        pend = 8'h20;
        exp_q.push_back(3'd5);
        step();
        tests++; if (clear !== 8'h00) begin errors++; $display("FAIL fx_clear1 got %h exp 00", clear); end
        step();
        tests++; if (irq !== 1'b0) begin errors++; $display("FAIL fx_gap got %b exp 0", irq); end
        step();
        tests++; if (irq !== 1'b1) begin errors++; $display("FAIL fx_reirq got %b exp 1", irq); end
        exp_id = exp_q.pop_front();
        tests++; if (int_id !== exp_id) begin errors++; $display("FAIL fx_id2 got %0d exp %0d", int_id, exp_id); end
        ack = 1; step(); ack = 0;
        tests++; if (clear !== 8'h20) begin errors++; $display("FAIL fx_clear2 got %h exp 20", clear); end
        pend = 0;
        step(); step(); step();
    endtask

    task automatic test_mask();
        pend = 8'h01;
        exp_q.push_back(3'd0);
        step();
        exp_id = exp_q.pop_front();
        tests++; if (irq !== 1'b1 || int_id !== exp_id) begin errors++; $display("FAIL mk_irq got %b/%0d exp 1/%0d", irq, int_id, exp_id); end
        mask = 8'h01;
        step();
        tests++; if (irq !== 1'b0) begin errors++; $display("FAIL mk_withdraw got %b exp 0", irq); end
        tests++; if (clear !== 8'h00) begin errors++; $display("FAIL mk_clear got %h exp 00", clear); end
        tests++; if (pstat !== 8'h00) begin errors++; $display("FAIL mk_pstat got %h exp 00", pstat); end
        step();
        tests++; if (irq !== 1'b0 || clear !== 8'h00) begin errors++; $display("FAIL mk_stay got %b/%h exp 0/00", irq, clear); end
        pend = 0; mask = 0;
        step();
    endtask

    task automatic test_round_robin();
        logic [2:0] k3;
        bit         seen;
        ge_r = 1; mask_r = 0; pend_r = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            k3 = 3'(k % 8);
            exp_q.push_back(k3);
            seen = 0;
            for (int c = 0; c < 8 && !seen; c++) begin
                step();
                seen = irq_r;
            end
            tests++;
            if (!seen) begin
                errors++; $display("FAIL rr_timeout got irq 0 exp 1 at k=%0d", k);
                void'(exp_q.pop_front());
            end else begin
                exp_id = exp_q.pop_front();
                if (int_id_r !== exp_id) begin errors++; $display("FAIL rr_id got %0d exp %0d", int_id_r, exp_id); end
            end
            ack_r = 1; step(); ack_r = 0;
            tests++; if (clear_r !== (8'h01 << k3)) begin errors++; $display("FAIL rr_clear got %h exp %h", clear_r, 8'h01 << k3); end
        end
        pend_r = 0;
        step(); step(); step();
    endtask

    task automatic test_no_preempt();
        pend = 8'h10;
        exp_q.push_back(3'd4);
        step();
        exp_id = exp_q.pop_front();
        tests++; if (irq !== 1'b1 || int_id !== exp_id) begin errors++; $display("FAIL np_irq got %b/%0d exp 1/%0d", irq, int_id, exp_id); end
        pend = 8'h12;
        step(); step();
        tests++; if (irq !== 1'b1 || int_id !== 3'd4) begin errors++; $display("FAIL np_hold got %b/%0d exp 1/4", irq, int_id); end
        ack = 1; step(); ack = 0;
        tests++; if (clear !== 8'h10) begin errors++; $display("FAIL np_clear got %h exp 10", clear); end
        pend = 8'h02;
        exp_q.push_back(3'd1);
        step(); step(); step();
        exp_id = exp_q.pop_front();
        tests++; if (irq !== 1'b1 || int_id !== exp_id) begin errors++; $display("FAIL np_next got %b/%0d exp 1/%0d", irq, int_id, exp_id); end
        ack = 1; step(); ack = 0;
        pend = 0;
        step(); step(); step();
    endtask

    task automatic test_global_en();
        ge = 0; pend = 8'h10;
        step(); step();
        tests++; if (irq !== 1'b0) begin errors++; $display("FAIL ge_off got %b exp 0", irq); end
        tests++; if (pstat !== 8'h10) begin errors++; $display("FAIL ge_pstat got %h exp 10", pstat); end
        ge = 1;
        exp_q.push_back(3'd4);
        step();
        exp_id = exp_q.pop_front();
        tests++; if (irq !== 1'b1 || int_id !== exp_id) begin errors++; $display("FAIL ge_on got %b/%0d exp 1/%0d", irq, int_id, exp_id); end
        ge = 0;
        step();
        tests++; if (irq !== 1'b0 || clear !== 8'h00) begin errors++; $display("FAIL ge_withdraw got %b/%h exp 0/00", irq, clear); end
        step();
        tests++; if (clear !== 8'h00) begin errors++; $display("FAIL ge_noclear got %h exp 00", clear); end
        pend = 0; ge = 1;
        step();
    endtask

    task automatic test_reset_mid();
        pend = 8'h08;
        exp_q.push_back(3'd3);
        step();
        exp_id = exp_q.pop_front();
        tests++; if (irq !== 1'b1 || int_id !== exp_id) begin errors++; $display("FAIL rm_irq got %b/%0d exp 1/%0d", irq, int_id, exp_id); end
        ack = 1; step(); ack = 0;
        tests++; if (clear !== 8'h08) begin errors++; $display("FAIL rm_clear got %h exp 08", clear); end
        RESETn = 0;
        step();
        tests++; if (irq !== 1'b0 || int_id !== 3'd0 || clear !== 8'h00 || pstat !== 8'h00) begin
            errors++; $display("FAIL rm_reset got %b/%0d/%h/%h exp 0/0/00/00", irq, int_id, clear, pstat);
        end
        RESETn = 1;
        pend_r = 8'hFF;
        exp_q.push_back(3'd3);
        step();
        exp_id = exp_q.pop_front();
        tests++; if (irq !== 1'b1 || int_id !== exp_id) begin errors++; $display("FAIL rm_idle got %b/%0d exp 1/%0d", irq, int_id, exp_id); end
        tests++; if (irq_r !== 1'b1 || int_id_r !== 3'd0) begin errors++; $display("FAIL rm_ptr got %b/%0d exp 1/0", irq_r, int_id_r); end
        tests++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_left got %0d exp 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_mask();
        test_round_robin();
        test_no_preempt();
        test_global_en();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
